// File: rtl/pwm_hbridge_driver.sv
// Sign/magnitude PWM driver for one H-bridge motor leg pair.
// Latches PID effort once per period, saturates, adds reversal dead-time.
module pwm_hbridge_driver #(
  parameter int W        = 7,
  parameter int CNT_W    = 8,
  parameter int PERIOD   = 127,
  parameter int DEADTIME = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W:0]   u_in,
  output logic         pwm_a,
  output logic         pwm_b,
  output logic         dir,
  output logic         sat,
  output logic         period_tick
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DEAD = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST    = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0] DT_LAST = CNT_W'(DEADTIME - 1);
  localparam logic [CNT_W-1:0] FULL    = CNT_W'(PERIOD);

  state_t           state;
  state_t           state_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic [CNT_W-1:0] duty;
  logic [CNT_W-1:0] duty_n;
  logic             pend;
  logic             pend_n;
  logic             dir_n;
  logic             sat_n;
  logic             act_n;
  logic             tick_n;

  logic             sign;
  logic [W:0]       mag;
  logic             over;
  logic [CNT_W-1:0] clip;
  logic             boundary;

  // Unsigned magnitude; -2**W maps to 2**W without overflow.
  always_comb begin
    sign = u_in[W];
    mag  = sign ? (~u_in + 1'b1) : u_in;
    over = (32'(mag) > 32'(PERIOD));
    clip = over ? FULL : CNT_W'(mag);
  end

  // Next state, counter, latched duty and direction.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    duty_n   = duty;
    pend_n   = pend;
    dir_n    = dir;
    sat_n    = sat;
    boundary = (cnt == LAST);
    if (!en) begin
      state_n = IDLE;
      cnt_n   = '0;
      duty_n  = '0;
      sat_n   = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          state_n = RUN;
          cnt_n   = '0;
          duty_n  = '0;
          sat_n   = 1'b0;
        end
        RUN, DEAD: begin
          cnt_n = boundary ? '0 : cnt + 1'b1;
          if (boundary) begin
            duty_n = clip;
            sat_n  = over;
            if ((mag != '0) && (sign != dir)) begin
              state_n = DEAD;
              pend_n  = sign;
            end
          end
          if ((state == DEAD) && (cnt == DT_LAST)) begin
            state_n = RUN;
            dir_n   = pend;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Output decode from the next-cycle values so outputs stay registered.
  always_comb begin
    act_n  = (state_n == RUN) && (cnt_n < duty_n);
    tick_n = (state_n != IDLE) && (cnt_n == LAST);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      duty        <= '0;
      pend        <= 1'b0;
      dir         <= 1'b0;
      sat         <= 1'b0;
      pwm_a       <= 1'b0;
      pwm_b       <= 1'b0;
      period_tick <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      duty        <= duty_n;
      pend        <= pend_n;
      dir         <= dir_n;
      sat         <= sat_n;
      pwm_a       <= act_n & ~dir_n;
      pwm_b       <= act_n & dir_n;
      period_tick <= tick_n;
    end
  end

endmodule

// File: tb/tb_pwm_hbridge_driver.sv
// Directed bench for pwm_hbridge_driver.
// Measures each PWM period leg-by-leg against hand-computed counts.
module tb_pwm_hbridge_driver;

  localparam int P  = 127;
  localparam int DT = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [7:0] u_in;
  logic       pwm_a;
  logic       pwm_b;
  logic       dir;
  logic       sat;
  logic       period_tick;

  pwm_hbridge_driver #(
    .W(7), .CNT_W(8), .PERIOD(P), .DEADTIME(DT)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .u_in(u_in),
    .pwm_a(pwm_a), .pwm_b(pwm_b), .dir(dir), .sat(sat),
    .period_tick(period_tick)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;
  int fails  = 0;

  int na, nb, nt, nd, ns;
  int a_first, a_last, b_first, b_last, tick_at;

  int overlap = 0;
  int gapv    = 0;
  int since_a = 1000;
  int since_b = 1000;

  // Bridge invariants watched on every cycle.
  always @(negedge clk) begin
    if (pwm_a && pwm_b) overlap++;
    if (pwm_a && since_b < DT) gapv++;
    if (pwm_b && since_a < DT) gapv++;
    since_a = pwm_a ? 0 : (since_a < 1000 ? since_a + 1 : 1000);
    since_b = pwm_b ? 0 : (since_b < 1000 ? since_b + 1 : 1000);
  end

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One full period starting at cnt==0; optional u change at index chg_i.
  task automatic measure(input int chg_i, input logic [7:0] chg_u);
    na = 0; nb = 0; nt = 0; nd = 0; ns = 0;
    a_first = -1; a_last = -1; b_first = -1; b_last = -1; tick_at = -1;
    for (int i = 0; i < P; i++) begin
      @(negedge clk);
      if (pwm_a) begin
        na++;
        if (a_first < 0) a_first = i;
        a_last = i;
      end
      if (pwm_b) begin
        nb++;
        if (b_first < 0) b_first = i;
        b_last = i;
      end
      if (period_tick) begin
        nt++;
        tick_at = i;
      end
      if (dir) nd++;
      if (sat) ns++;
      if (i == chg_i) u_in = chg_u;
    end
  endtask

  initial begin
    reset = 1'b1;
    en    = 1'b0;
    u_in  = 8'd0;
    #2 reset = 1'b0;
    #1;
    chk("rst_a", int'(pwm_a), 0);
    chk("rst_b", int'(pwm_b), 0);
    chk("rst_dir", int'(dir), 0);
    chk("rst_sat", int'(sat), 0);
    chk("rst_tick", int'(period_tick), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_a", int'(pwm_a), 0);
    chk("idle_tick", int'(period_tick), 0);

    // first period after enable drives zero duty
    u_in = 8'd64;
    en   = 1'b1;
    measure(-1, 8'd0);
    chk("p1_na", na, 0);
    chk("p1_nt", nt, 1);
    chk("p1_tick_at", tick_at, P - 1);

    // +64 steady
    measure(-1, 8'd0);
    chk("p2_na", na, 64);
    chk("p2_a_first", a_first, 0);
    chk("p2_a_last", a_last, 63);
    chk("p2_nb", nb, 0);
    chk("p2_nd", nd, 0);
    chk("p2_ns", ns, 0);
    chk("p2_nt", nt, 1);

    // -128: reversal then full saturated drive
    u_in = 8'h80;
    measure(-1, 8'd0);
    chk("p3_nb", nb, 123);
    chk("p3_b_first", b_first, DT);
    chk("p3_na", na, 0);
    chk("p3_nd", nd, 123);
    chk("p3_ns", ns, P);
    measure(-1, 8'd0);
    chk("p4_nb", nb, P);
    chk("p4_na", na, 0);
    chk("p4_nd", nd, P);
    chk("p4_ns", ns, P);

    // +50 then -50 reversals
    u_in = 8'd50;
    measure(-1, 8'd0);
    chk("p5_na", na, 46);
    chk("p5_a_first", a_first, DT);
    chk("p5_a_last", a_last, 49);
    chk("p5_nd", nd, DT);
    chk("p5_ns", ns, 0);
    measure(-1, 8'd0);
    chk("p6_na", na, 50);
    u_in = 8'hCE;
    measure(-1, 8'd0);
    chk("p7_nb", nb, 46);
    chk("p7_b_first", b_first, DT);
    chk("p7_b_last", b_last, 49);
    chk("p7_na", na, 0);
    measure(-1, 8'd0);
    chk("p8_nb", nb, 50);

    // mid-period change ignored until next boundary
    u_in = 8'd20;
    measure(-1, 8'd0);
    chk("p9_na", na, 16);
    measure(10, 8'd100);
    chk("p10_na", na, 20);
    chk("p10_a_last", a_last, 19);
    measure(-1, 8'd0);
    chk("p11_na", na, 100);
    chk("p11_a_last", a_last, 99);

    // zero period: nothing driven, no dead-time afterwards
    u_in = 8'd0;
    measure(-1, 8'd0);
    chk("p12_na", na, 0);
    chk("p12_nb", nb, 0);
    chk("p12_nd", nd, 0);
    u_in = 8'd30;
    measure(-1, 8'd0);
    chk("p13_na", na, 30);
    chk("p13_a_first", a_first, 0);
    u_in = 8'hE2;
    measure(-1, 8'd0);
    chk("p14_nb", nb, 26);
    chk("p14_b_first", b_first, DT);
    u_in = 8'd30;
    measure(-1, 8'd0);
    chk("p15_na", na, 26);

    // en drop at cnt 5 with pwm_a high
    for (int i = 0; i < 6; i++) @(negedge clk);
    chk("en_pre_a", int'(pwm_a), 1);
    en = 1'b0;
    @(negedge clk);
    chk("en_off_a", int'(pwm_a), 0);
    chk("en_off_b", int'(pwm_b), 0);
    chk("en_off_tick", int'(period_tick), 0);
    chk("en_off_dir", int'(dir), 0);
    en = 1'b1;
    measure(-1, 8'd0);
    chk("re_na", na, 0);
    chk("re_tick_at", tick_at, P - 1);
    measure(-1, 8'd0);
    chk("re2_na", na, 30);

    // async reset at cnt 20 with pwm_a high
    for (int i = 0; i < 21; i++) @(negedge clk);
    chk("ar_pre_a", int'(pwm_a), 1);
    #1 reset = 1'b0;
    #1;
    chk("ar_a", int'(pwm_a), 0);
    chk("ar_b", int'(pwm_b), 0);
    chk("ar_sat", int'(sat), 0);
    chk("ar_tick", int'(period_tick), 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    chk("overlap", overlap, 0);
    chk("gap", gapv, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
